rggen_bus_arbiter: RTL and testbench

RGGEN_BUS_ARBITER -- requirements
Module: rggen_bus_arbiter

---
 rtl/rggen_rtl_pkg.sv | 13 +
 rtl/rggen_round_robin_selector.sv | 27 ++
 rtl/rggen_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types and response codes for the register-bus arbiter slice.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    RESPONSE = 2'b10
  } rggen_arbiter_state_e;

  localparam logic [1:0] OKAY        = 2'b00;
  localparam logic [1:0] SLAVE_ERROR = 2'b10;

endpackage

// File: rtl/rggen_round_robin_selector.sv
// Round-robin pick: first requester at or after the pointer, wrapping to index 0.
module rggen_round_robin_selector #(
  parameter int REQUESTERS    = 2,
  parameter int POINTER_WIDTH = $clog2(REQUESTERS)
)(
  input  logic [REQUESTERS-1:0]    i_request,
  input  logic [POINTER_WIDTH-1:0] i_pointer,
  output logic [REQUESTERS-1:0]    o_grant
);

  logic [REQUESTERS-1:0] upper_mask;
  logic [REQUESTERS-1:0] upper_request;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  // x & -x isolates the lowest set bit.
  assign upper_mask    = '1 << i_pointer;
  assign upper_request = i_request & upper_mask;

  always_comb begin
    if (|upper_request) begin
      o_grant = upper_request & (~upper_request + REQUESTERS'(1));
    end else begin
      o_grant = i_request & (~i_request + REQUESTERS'(1));
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Arbitrates several register-bus requesters onto one bus with a response watchdog.
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 64
)(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REQUESTERS-1:0]                  i_valid,
  input  logic [REQUESTERS-1:0]                  i_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]    i_address,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]       i_write_data,
  input  logic [REQUESTERS*(DATA_WIDTH/8)-1:0]   i_strobe,
  output logic [REQUESTERS-1:0]                  o_done,
  output logic [DATA_WIDTH-1:0]                  o_read_data,
  output logic [1:0]                             o_status,
  output logic                                   o_bus_request,
  output logic                                   o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]               o_bus_address,
  output logic [DATA_WIDTH-1:0]                  o_bus_write_data,
  output logic [DATA_WIDTH/8-1:0]                o_bus_strobe,
  input  logic                                   i_bus_done,
  input  logic [DATA_WIDTH-1:0]                  i_bus_read_data,
  input  logic [1:0]                             i_bus_status
);

  localparam int          STROBE_WIDTH  = DATA_WIDTH / 8;
  localparam int          POINTER_WIDTH = $clog2(REQUESTERS);
  localparam int          COUNT_WIDTH   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned REQ_COUNT     = REQUESTERS;

  rggen_arbiter_state_e         state;
  logic [POINTER_WIDTH-1:0]     pointer;
  logic [REQUESTERS-1:0]        grant;
  logic                         cmd_write;
  logic [ADDRESS_WIDTH-1:0]     cmd_address;
  logic [DATA_WIDTH-1:0]        cmd_write_data;
  logic [STROBE_WIDTH-1:0]      cmd_strobe;
  logic [DATA_WIDTH-1:0]        resp_data;
  logic [1:0]                   resp_status;
  logic [COUNT_WIDTH-1:0]       timeout_count;

  logic [REQUESTERS-1:0]        grant_onehot;
  logic [POINTER_WIDTH-1:0]     grant_index;
  logic [POINTER_WIDTH-1:0]     next_pointer;
  logic                         sel_write;
  logic [ADDRESS_WIDTH-1:0]     sel_address;
  logic [DATA_WIDTH-1:0]        sel_write_data;
  logic [STROBE_WIDTH-1:0]      sel_strobe;
  logic                         timeout_hit;
  logic                         in_access;
  logic                         in_response;

  rggen_round_robin_selector #(
    .REQUESTERS    (REQUESTERS),
    .POINTER_WIDTH (POINTER_WIDTH)
  ) u_selector (
    .i_request (i_valid),
    .i_pointer (pointer),
    .o_grant   (grant_onehot)
  );

  always_comb begin
    grant_index    = '0;
    sel_write      = 1'b0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_strobe     = '0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      if (grant_onehot[i]) begin
        grant_index    = POINTER_WIDTH'(i);
        sel_write      = i_write[i];
        sel_address    = i_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write_data = i_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strobe     = i_strobe[i*STROBE_WIDTH +: STROBE_WIDTH];
      end
    end
  end

  assign next_pointer = (grant_index == POINTER_WIDTH'(REQUESTERS - 1))
                      ? '0 : grant_index + POINTER_WIDTH'(1);

  // Count holds completed ACCESS cycles, so TIMEOUT-1 marks the last allowed one.
  assign timeout_hit = (TIMEOUT > 0) && (timeout_count == COUNT_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pointer        <= '0;
      grant          <= '0;
      cmd_write      <= 1'b0;
      cmd_address    <= '0;
      cmd_write_data <= '0;
      cmd_strobe     <= '0;
      resp_data      <= '0;
      resp_status    <= OKAY;
      timeout_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|i_valid) begin
            grant          <= grant_onehot;
            pointer        <= next_pointer;
            cmd_write      <= sel_write;
            cmd_address    <= sel_address;
            cmd_write_data <= sel_write_data;
            cmd_strobe     <= sel_strobe;
            timeout_count  <= '0;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          if (i_bus_done) begin
            resp_data     <= i_bus_read_data;
            resp_status   <= i_bus_status;
            timeout_count <= '0;
            state         <= RESPONSE;
          end else if (timeout_hit) begin
            resp_data     <= '0;
            resp_status   <= SLAVE_ERROR;
            timeout_count <= '0;
            state         <= RESPONSE;
          end else if (TIMEOUT > 0) begin
            timeout_count <= timeout_count + COUNT_WIDTH'(1);
          end
        end
        RESPONSE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign in_access   = (state == ACCESS);
  assign in_response = (state == RESPONSE);

  assign o_bus_request    = in_access;
  assign o_bus_write      = in_access & cmd_write;
  assign o_bus_address    = in_access ? cmd_address    : '0;
  assign o_bus_write_data = in_access ? cmd_write_data : '0;
  assign o_bus_strobe     = in_access ? cmd_strobe     : '0;

  assign o_done      = in_response ? grant       : '0;
  assign o_read_data = in_response ? resp_data   : '0;
  assign o_status    = in_response ? resp_status : OKAY;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Scoreboard bench for rggen_bus_arbiter: directed scenarios then randomized traffic.
module tb_rggen_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    i_valid, i_write, o_done;
  logic [N*AW-1:0] i_address;
  logic [N*DW-1:0] i_write_data;
  logic [N*SW-1:0] i_strobe;
  logic [DW-1:0]   o_read_data, o_bus_write_data, i_bus_read_data;
  logic [1:0]      o_status, i_bus_status;
  logic            o_bus_request, o_bus_write, i_bus_done;
  logic [AW-1:0]   o_bus_address;
  logic [SW-1:0]   o_bus_strobe;

  logic          req_valid [N];
  logic          req_write [N];
  logic [AW-1:0] req_addr  [N];
  logic [DW-1:0] req_wdata [N];
  logic [SW-1:0] req_strb  [N];

  typedef struct {
    int          grant;
    logic [DW-1:0] data;
    logic [1:0]  status;
  } resp_t;

  resp_t exp_q[$];
  int    grant_log[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  bit            directed = 1'b1;
  bit            noise = 1'b0;
  int            force_delay = 0;
  logic [DW-1:0] force_data = '0;
  logic [1:0]    force_status = 2'b00;

  rggen_bus_arbiter #(
    .REQUESTERS    (N),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT       (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_valid          (i_valid),
    .i_write          (i_write),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_strobe         (i_strobe),
    .o_done           (o_done),
    .o_read_data      (o_read_data),
    .o_status         (o_status),
    .o_bus_request    (o_bus_request),
    .o_bus_write      (o_bus_write),
    .o_bus_address    (o_bus_address),
    .o_bus_write_data (o_bus_write_data),
    .o_bus_strobe     (o_bus_strobe),
    .i_bus_done       (i_bus_done),
    .i_bus_read_data  (i_bus_read_data),
    .i_bus_status     (i_bus_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    i_valid      = '0;
    i_write      = '0;
    i_address    = '0;
    i_write_data = '0;
    i_strobe     = '0;
    for (int i = 0; i < N; i++) begin
      i_valid[i]               = req_valid[i];
      i_write[i]               = req_write[i];
      i_address[i*AW +: AW]    = req_addr[i];
      i_write_data[i*DW +: DW] = req_wdata[i];
      i_strobe[i*SW +: SW]     = req_strb[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first valid requester at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int o = 0; o < N; o++) begin
      int idx;
      idx = (p + o) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Bus responder plus output monitor, evaluated on every falling edge.
  initial begin : monitor
    resp_t         e;
    bit            in_access;
    int            acc, plan, exp_len, g, ptr, idx;
    logic [DW-1:0] pdata;
    logic [1:0]    pstat;
    logic [N-1:0]  valid_prev;
    in_access = 1'b0; acc = 0; plan = 0; exp_len = 0; g = 0; ptr = 0;
    pdata = '0; pstat = 2'b00; valid_prev = '0;
    i_bus_done = 1'b0; i_bus_read_data = '0; i_bus_status = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_bus_request", 64'(o_bus_request), 0);
        check("rst_bus_cmd", 64'({o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe}), 0);
        check("rst_done_status", 64'({o_done, o_status}), 0);
        check("rst_read_data", 64'(o_read_data), 0);
        in_access = 1'b0;
        ptr = 0;
        exp_q.delete();
        i_bus_done = 1'b0;
      end else begin
        if (o_bus_request) begin
          if (!in_access) begin
            in_access = 1'b1;
            acc = 0;
            g = pick(valid_prev, ptr);
            check("grant_had_request", 64'(g >= 0), 1);
            if (g < 0) g = 0;
            ptr = (g + 1) % N;
            if (directed) begin
              plan = force_delay; pdata = force_data; pstat = force_status;
            end else begin
              plan = int'($urandom_range(0, 5));
              pdata = $urandom;
              pstat = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
            end
            if (plan < TO) begin
              e = '{g, pdata, pstat};
              exp_len = plan + 1;
            end else begin
              e = '{g, '0, 2'b10};
              exp_len = TO;
            end
            exp_q.push_back(e);
          end
          check("bus_command", 64'({o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe}),
                64'({req_write[g], req_addr[g], req_wdata[g], req_strb[g]}));
          i_bus_done      = (acc == plan);
          i_bus_read_data = (acc == plan) ? pdata : $urandom;
          i_bus_status    = (acc == plan) ? pstat : 2'($urandom);
          acc++;
          if (acc > TO + 4) begin
            check("access_watchdog", 64'(acc), 64'(exp_len));
            in_access = 1'b0;
          end
        end else begin
          if (in_access) begin
            check("access_length", 64'(acc), 64'(exp_len));
            in_access = 1'b0;
          end
          i_bus_done      = noise && ($urandom_range(0, 3) == 0);
          i_bus_read_data = $urandom;
          i_bus_status    = 2'($urandom);
        end
        if (o_done != '0) begin
          idx = -1;
          for (int i = 0; i < N; i++) if (o_done[i]) idx = i;
          grant_log.push_back(idx);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(o_done), 0);
          end else begin
            e = exp_q.pop_front();
            check("done_onehot", 64'(o_done), 64'(N'(1) << e.grant));
            check("read_data", 64'(o_read_data), 64'(e.data));
            check("status", 64'(o_status), 64'(e.status));
          end
        end else begin
          check("idle_response_zero", 64'({o_read_data, o_status}), 0);
        end
      end
      valid_prev = i_valid;
    end
  end

  task automatic set_cmd(input int k, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[k] = w; req_addr[k] = a; req_wdata[k] = d; req_strb[k] = s;
  endtask

  task automatic wait_done(input int k);
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (o_done[k]) break;
    end
    check($sformatf("done_seen_%0d", k), 64'(t < 100), 1);
  endtask

  task automatic wait_bus_request();
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_bus_request) break;
    end
    check("bus_request_seen", 64'(t < 50), 1);
  endtask

  task automatic run_req(input int k, input int n, input bit rnd);
    for (int t = 0; t < n; t++) begin
      int gap;
      gap = rnd ? int'($urandom_range(0, 3)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      set_cmd(k, 1'($urandom), AW'($urandom), $urandom, SW'($urandom));
      req_valid[k] = 1'b1;
      wait_done(k);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
    end
  endtask

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    int t0, base;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      set_cmd(i, 1'b0, '0, '0, '0);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single read with immediate bus response.
    directed = 1'b1; force_delay = 0; force_data = 32'h12345678; force_status = 2'b00;
    @(posedge clk); #1;
    set_cmd(0, 1'b0, 8'h04, '0, 4'hF);
    req_valid[0] = 1'b1;
    t0 = cyc;
    wait_done(0);
    check("min_latency", 64'(cyc - t0), 2);
    @(posedge clk); #1 req_valid[0] = 1'b0;

    // Write with partial strobes from requester 1.
    force_delay = 1; force_data = 32'h0; force_status = 2'b00;
    set_cmd(1, 1'b1, 8'h08, 32'hA5A5A5A5, 4'b0011);
    req_valid[1] = 1'b1;
    wait_bus_request();
    check("wr_write", 64'(o_bus_write), 1);
    check("wr_data", 64'(o_bus_write_data), 64'h00000000A5A5A5A5);
    check("wr_strobe", 64'(o_bus_strobe), 64'h3);
    check("wr_address", 64'(o_bus_address), 64'h08);
    wait_done(1);
    @(posedge clk); #1 req_valid[1] = 1'b0;

    // Fairness with both requesters held valid.
    force_delay = 0; force_data = 32'h600DF00D;
    base = grant_log.size();
    fork
      run_req(0, 2, 1'b0);
      run_req(1, 2, 1'b0);
    join
    check("fair_count", 64'(grant_log.size() - base), 4);
    for (int i = 0; i < 4; i++)
      if (base + i < grant_log.size())
        check($sformatf("fair_order_%0d", i), 64'(grant_log[base + i]), 64'(i % 2));

    // Bus never responds: watchdog.
    force_delay = 99;
    set_cmd(0, 1'b0, 8'h20, '0, 4'hF);
    req_valid[0] = 1'b1;
    wait_done(0);
    @(posedge clk); #1 req_valid[0] = 1'b0;

    // Response on the final allowed cycle wins over the watchdog.
    force_delay = TO - 1; force_data = 32'hCAFEF00D; force_status = 2'b00;
    set_cmd(1, 1'b0, 8'h24, '0, 4'hF);
    req_valid[1] = 1'b1;
    wait_done(1);
    @(posedge clk); #1 req_valid[1] = 1'b0;

    // Reset during the second ACCESS cycle of a grant to requester 0.
    force_delay = 99; force_data = 32'h13572468; force_status = 2'b10;
    base = grant_log.size();
    set_cmd(0, 1'b0, 8'h30, '0, 4'hF);
    set_cmd(1, 1'b1, 8'h34, 32'h0BADBEEF, 4'b1100);
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    wait_bus_request();
    check("pre_reset_grant0", 64'(o_bus_address), 64'h30);
    @(posedge clk); #1;
    rst = 1'b1;
    force_delay = 0;
    #1 check("reset_abort_request", 64'(o_bus_request), 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_done(0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_done(1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    check("post_reset_done_count", 64'(grant_log.size() - base), 2);
    if (grant_log.size() > base)
      check("post_reset_first_grant", 64'(grant_log[base]), 0);

    // Randomized traffic with bus noise outside ACCESS.
    directed = 1'b0; noise = 1'b1;
    fork
      run_req(0, 30, 1'b1);
      run_req(1, 30, 1'b1);
    join
    noise = 1'b0;
    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
